// File: rtl/display_pkg.sv
// Shared types and digit-enable encodings for the two-digit display multiplexer.
package display_pkg;

   typedef logic [3:0] nibble_t;

   typedef enum logic [1:0] {
      BLANK1,
      SHOW0,
      BLANK0,
      SHOW1
   } mux_state_t;

   // Enables are active-low: bit k low lights digit k.
   localparam logic [1:0] DIG_OFF = 2'b11;
   localparam logic [1:0] DIG0_ON = 2'b10;
   localparam logic [1:0] DIG1_ON = 2'b01;

endpackage

// File: rtl/display_mux_if.sv
// Bundle of display value inputs and decoder/enable outputs for display_mux.
interface display_mux_if;
   import display_pkg::*;

   logic       enable;
   nibble_t    digit0;
   nibble_t    digit1;
   nibble_t    bin_out;
   logic [1:0] digit_en_n;

   modport master (
      output enable, digit0, digit1,
      input  bin_out, digit_en_n
   );

   modport slave (
      input  enable, digit0, digit1,
      output bin_out, digit_en_n
   );

endinterface

// File: rtl/display_mux.sv
// Two-digit time multiplexer with dead-time blanking between digit slots.
// Optional build macro DISPLAY_MUX_LEADING_ZERO_BLANK_EN keeps a zero left digit dark.
//
// state  | meaning
// BLANK1 | dead time after digit 1 (also the idle / disabled state)
// SHOW0  | right digit lit, bin_out = digit0 captured on entry
// BLANK0 | dead time after digit 0
// SHOW1  | left digit lit, bin_out = digit1 captured on entry
module display_mux
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 24000,
   parameter int DEAD_CYCLES = 480
) (
   input  logic         clk,
   input  logic         reset,
   display_mux_if.slave bus
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] BLANK_LAST = CW'(DEAD_CYCLES - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - DEAD_CYCLES - 1);

   if (DEAD_CYCLES < 1 || DEAD_CYCLES >= REFRESH_DIV) begin : g_param_check
      $error("display_mux: DEAD_CYCLES must satisfy 1 <= DEAD_CYCLES < REFRESH_DIV");
   end

   mux_state_t    state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   nibble_t       bin_nx;
   logic [1:0]    en_nx;
   logic          last;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= BLANK1;
         cnt            <= '0;
         bus.digit_en_n <= DIG_OFF;
         bus.bin_out    <= '0;
      end else begin
         state          <= state_nx;
         cnt            <= cnt_nx;
         bus.digit_en_n <= en_nx;
         bus.bin_out    <= bin_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 1'b1;
      bin_nx   = bus.bin_out;
      en_nx    = bus.digit_en_n;
      last     = (state == SHOW0 || state == SHOW1) ? (cnt == SHOW_LAST)
                                                     : (cnt == BLANK_LAST);

      if (!bus.enable) begin
         state_nx = BLANK1;
         cnt_nx   = '0;
         en_nx    = DIG_OFF;
      end else if (last) begin
         cnt_nx = '0;
         // Segment data only changes while both digits are dark.
         case (state)
            BLANK1: begin
               state_nx = SHOW0;
               bin_nx   = bus.digit0;
               en_nx    = DIG0_ON;
            end
            SHOW0: begin
               state_nx = BLANK0;
               en_nx    = DIG_OFF;
            end
            BLANK0: begin
               state_nx = SHOW1;
               bin_nx   = bus.digit1;
`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
               en_nx    = (bus.digit1 == 4'h0) ? DIG_OFF : DIG1_ON;
`else
               en_nx    = DIG1_ON;
`endif
            end
            SHOW1: begin
               state_nx = BLANK1;
               en_nx    = DIG_OFF;
            end
            default: begin
               state_nx = BLANK1;
               en_nx    = DIG_OFF;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_display_mux.sv
// Self-checking bench for display_mux: frame-position model plus directed literal checks.
module tb_display_mux;

   localparam int R = 8;
   localparam int D = 2;
`ifdef DISPLAY_MUX_LEADING_ZERO_BLANK_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   tests  = 0;
   int   failed = 0;

   display_mux_if dif ();

   display_mux #(.REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dif)
   );

   always #5 clk = ~clk;

   // Model: position within a 2*R frame, restarted by reset or enable low.
   int         pos     = 0;
   bit         m_valid = 1'b0;
   logic [3:0] m_bin;
   logic [1:0] m_en;

   always @(posedge clk) begin
      if (reset) begin
         pos = 0; m_bin = 4'h0; m_en = 2'b11; m_valid = 1'b1;
      end else if (m_valid) begin
         if (!dif.enable) begin
            pos = 0; m_en = 2'b11;
         end else begin
            pos = (pos + 1) % (2 * R);
            if (pos == D) begin
               m_bin = dif.digit0; m_en = 2'b10;
            end else if (pos == R + D) begin
               m_bin = dif.digit1;
               m_en  = (LZB && dif.digit1 == 4'h0) ? 2'b11 : 2'b01;
            end else if (pos == R || pos == 0) begin
               m_en = 2'b11;
            end
         end
      end
   end

   logic [1:0] prev_en  = 2'b11;
   logic [3:0] prev_bin = 4'h0;

   always @(negedge clk) begin
      if (m_valid) begin
         tests++;
         if (dif.digit_en_n !== m_en || dif.bin_out !== m_bin) begin
            failed++;
            $display("FAIL model t=%0t pos=%0d: got en=%b bin=%h, required en=%b bin=%h",
                     $time, pos, dif.digit_en_n, dif.bin_out, m_en, m_bin);
         end
         tests++;
         if (dif.digit_en_n === 2'b00) begin
            failed++;
            $display("FAIL both_lit t=%0t: got en=%b, required not 00", $time, dif.digit_en_n);
         end
         if (dif.digit_en_n != 2'b11 && dif.digit_en_n == prev_en) begin
            tests++;
            if (dif.bin_out !== prev_bin) begin
               failed++;
               $display("FAIL bin_stable t=%0t: got bin=%h, required %h", $time, dif.bin_out, prev_bin);
            end
         end
         prev_en  = dif.digit_en_n;
         prev_bin = dif.bin_out;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [1:0] exp_en, input logic [3:0] exp_bin);
      tests++;
      if (dif.digit_en_n !== exp_en || dif.bin_out !== exp_bin) begin
         failed++;
         $display("FAIL %s: got en=%b bin=%h, required en=%b bin=%h",
                  name, dif.digit_en_n, dif.bin_out, exp_en, exp_bin);
      end
   endtask

   // Starts on the negedge just after the reset edge; ends at the second SHOW0 entry.
   task automatic frame_check(input logic [3:0] d0, input logic [3:0] d1);
      step(1); chk("blank1_a", 2'b11, 4'h0);
      step(1); chk("show0_entry", 2'b10, d0);
      step(5); chk("show0_last", 2'b10, d0);
      step(1); chk("blank0_a", 2'b11, d0);
      step(1); chk("blank0_b", 2'b11, d0);
      step(1); chk("show1_entry", 2'b01, d1);
      step(5); chk("show1_last", 2'b01, d1);
      step(1); chk("blank1_b", 2'b11, d1);
      step(2); chk("show0_again", 2'b10, d0);
   endtask

   initial begin
      reset = 1'b1;
      dif.enable = 1'b1;
      dif.digit0 = 4'h3;
      dif.digit1 = 4'h7;
      step(2);
      chk("reset_state", 2'b11, 4'h0);
      reset = 1'b0;
      frame_check(4'h3, 4'h7);

      step(3); dif.digit0 = 4'h9;
      step(1); chk("midslot_ignored", 2'b10, 4'h3);
      step(12); chk("next_show0_new", 2'b10, 4'h9);

      step(10); chk("show1_cycle2", 2'b01, 4'h7);
      dif.enable = 1'b0;
      step(1); chk("disable_dark", 2'b11, 4'h7);
      step(4); dif.enable = 1'b1;
      step(1); chk("enable_blank", 2'b11, 4'h7);
      step(1); chk("enable_show0", 2'b10, 4'h9);

      step(2); reset = 1'b1; dif.digit0 = 4'h3;
      step(1); chk("midshow_reset", 2'b11, 4'h0);
      reset = 1'b0;
      frame_check(4'h3, 4'h7);

      dif.digit1 = 4'h0;
      step(8); chk("zero_left", LZB ? 2'b11 : 2'b01, 4'h0);
      dif.digit1 = 4'h5;
      step(16); chk("left_five", 2'b01, 4'h5);
      step(5);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/display_mux.md
Name: display_mux

Overview:
- Time-multiplexes two 4-bit values onto a dual common-anode seven-segment display through a single shared decoder.
- Sits directly upstream of the seven-segment decoder: drives its 4-bit binary input and the per-digit active-low transistor enables.
- Inserts a blanking (dead-time) interval between digits so segment data never changes while a digit is lit, preventing ghosting.

Parameters:
- REFRESH_DIV, 24000, clk cycles per digit slot (SHOW + BLANK). At 48 MHz this gives 2 kHz slot rate, 1 kHz per digit.
- DEAD_CYCLES, 480, clk cycles of blanking at the end of each slot. Must satisfy 1 ≤ DEAD_CYCLES < REFRESH_DIV; violation is an elaboration-time assertion failure.

Ports:
- clk  input  1  system clock; the single clock, no other clock domains.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  display on; when low, both digits are dark.
- digit0  input  4  value for right digit (digit index 0).
- digit1  input  4  value for left digit (digit index 1).
- bin_out  output  4  nibble to decoder bin_in; registered.
- digit_en_n  output  2  active-low digit enables; bit k lights digit k; registered.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high (reset).
- Reset values, taking effect on the first clk edge with reset high:
  - state = BLANK1, cnt = 0
  - digit_en_n = 2'b11
  - bin_out = 4'h0
- FSM cycle: BLANK1 → SHOW0 → BLANK0 → SHOW1 → BLANK1.
- State lengths:
  - SHOWk lasts REFRESH_DIV−DEAD_CYCLES cycles.
  - BLANKk lasts DEAD_CYCLES cycles.
  - Full frame is 2·REFRESH_DIV cycles.
- cnt (width $clog2(REFRESH_DIV)) counts 0..len−1 within the current state. On cnt==len−1 the FSM advances and cnt←0.
- Entry into SHOWk happens on a single edge:
  - bin_out ← digitk, sampled on that edge.
  - digit_en_n[k] ← 0; the other bit stays 1.
- bin_out is held constant for the entire SHOW state. Input changes mid-slot are ignored until the next entry to that digit.
- On the edge leaving SHOWk, digit_en_n ← 2'b11. bin_out holds its last value through BLANK; it is only updated on SHOW entry.
- At most one bit of digit_en_n is ever 0. There is never a cycle with both digits lit.
- enable low, on any edge, in any state:
  - state ← BLANK1, cnt ← 0, digit_en_n ← 2'b11, bin_out held.
  - While enable stays low, the block stays in BLANK1 with cnt = 0.
- enable rising: counting resumes from BLANK1, cnt 0. SHOW0 is entered DEAD_CYCLES edges later.
- Priority: reset > enable low > normal advance.
- After reset deasserts (with enable high), SHOW0 is entered on the DEAD_CYCLES-th edge.

Optional Feature:
- Macro: DISPLAY_MUX_LEADING_ZERO_BLANK_EN.
- Defined: on entry to SHOW1, if digit1 == 4'h0:
  - digit_en_n stays 2'b11 for that slot; bin_out is still updated to 4'h0.
  - Timing and state sequence are unchanged.
- Undefined: digit1 is always displayed, including 0.

Decomposition:
- Package display_pkg holds:
  - typedef logic [3:0] nibble_t
  - enum mux_state_t {BLANK1, SHOW0, BLANK0, SHOW1}
  - localparam DIG_OFF = 2'b11
  - localparams DIG0_ON = 2'b10 and DIG1_ON = 2'b01
- No sub-module: counter and FSM fit in one module. The decoder is instantiated alongside it at the top level, not inside it.

Test Plan (REFRESH_DIV=8, DEAD_CYCLES=2, enable=1 unless stated):
- Reset, then release with digit0=4'h3, digit1=4'h7:
  - digit_en_n=2'b11 for 2 cycles.
  - Then 2'b10 with bin_out=4'h3 for 6 cycles.
  - Then 2'b11 for 2 cycles.
  - Then 2'b01 with bin_out=4'h7 for 6 cycles.
  - Period 16 repeats.
- Change digit0 from 4'h3 to 4'h9 at cycle 3 of SHOW0: bin_out stays 4'h3 through that slot and reads 4'h9 on the next SHOW0 entry.
- Drop enable during SHOW1 cycle 2:
  - Next edge: digit_en_n=2'b11, bin_out held.
  - Raise enable 5 cycles later: SHOW0 is entered exactly 2 edges after the rise.
- Assert reset mid-SHOW0: next edge gives digit_en_n=2'b11, bin_out=4'h0, and the sequence restarts as in scenario 1.
- Every cycle, a checker asserts digit_en_n != 2'b00. It also asserts bin_out is stable whenever digit_en_n != 2'b11.
- With DISPLAY_MUX_LEADING_ZERO_BLANK_EN defined and digit1=4'h0:
  - SHOW1 slot keeps digit_en_n=2'b11.
  - Setting digit1=4'h5 gives 2'b01 with bin_out=4'h5 on the next SHOW1.
